// File: rtl/hex_disp_pkg.sv
// Shared constants for the two-digit hex sum display: active-low segment
// glyphs (seg[6]=g ... seg[0]=a), digit-enable codes and the digit selector.
package hex_disp_pkg;

  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_A     = 7'b0001000;
  localparam logic [6:0] SEG_B     = 7'b0000011;
  localparam logic [6:0] SEG_C     = 7'b1000110;
  localparam logic [6:0] SEG_D     = 7'b0100001;
  localparam logic [6:0] SEG_E     = 7'b0000110;
  localparam logic [6:0] SEG_F     = 7'b0001110;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  // Active-low digit enables: an[0] is the sum digit, an[1] the carry digit.
  localparam logic [1:0] AN_OFF   = 2'b11;
  localparam logic [1:0] AN_SUM   = 2'b10;
  localparam logic [1:0] AN_CARRY = 2'b01;

  // Which digit the multiplexer is currently driving.
  typedef enum logic {
    DIG_SUM   = 1'b0,
    DIG_CARRY = 1'b1
  } digit_sel_e;

endpackage

// File: rtl/hex_to_7seg.sv
// Combinational hex-to-seven-segment decoder producing active-low glyphs.
module hex_to_7seg
  import hex_disp_pkg::*;
(
  input  logic [3:0] i_hex,
  output logic [6:0] o_seg
);

  // Look up the glyph for one hex nibble.
  always_comb begin
    o_seg = SEG_BLANK;
    case (i_hex)
      4'h0: o_seg = SEG_0;
      4'h1: o_seg = SEG_1;
      4'h2: o_seg = SEG_2;
      4'h3: o_seg = SEG_3;
      4'h4: o_seg = SEG_4;
      4'h5: o_seg = SEG_5;
      4'h6: o_seg = SEG_6;
      4'h7: o_seg = SEG_7;
      4'h8: o_seg = SEG_8;
      4'h9: o_seg = SEG_9;
      4'hA: o_seg = SEG_A;
      4'hB: o_seg = SEG_B;
      4'hC: o_seg = SEG_C;
      4'hD: o_seg = SEG_D;
      4'hE: o_seg = SEG_E;
      4'hF: o_seg = SEG_F;
      default: o_seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/hex_sum_display.sv
// Captures an adder's 4-bit sum and carry on a load rising edge and shows
// them on a two-digit multiplexed seven-segment display. All outputs are
// registered; they are computed from the next-state values so a capture
// shows up on the display in the very next cycle.
module hex_sum_display
  import hex_disp_pkg::*;
#(
  parameter int REFRESH_CNT = 50000,
  parameter bit BLANK_ZERO  = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic [3:0] sum_in,
  input  logic       carry_in,
  output logic       load_ack,
  output logic [6:0] seg,
  output logic [1:0] an,
  output logic       ovf_led
);

  localparam int               CNT_W    = (REFRESH_CNT > 2) ? $clog2(REFRESH_CNT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_CNT - 1);

  logic             r_loadPrev;
  logic [CNT_W-1:0] r_cnt;
  digit_sel_e       r_sel;
  logic [3:0]       r_sum;
  logic             r_carry;
  logic             r_valid;
  logic             r_loadAck;
  logic [6:0]       r_seg;
  logic [1:0]       r_an;
  logic             r_ovf;

  logic             w_loadEdge;
  logic             w_termCnt;
  logic [CNT_W-1:0] w_cntNext;
  digit_sel_e       w_selNext;
  logic [3:0]       w_sumNext;
  logic             w_carryNext;
  logic             w_validNext;
  logic [3:0]       w_digit;
  logic [6:0]       w_segDec;
  logic [6:0]       w_segNext;
  logic [1:0]       w_anNext;

  // Next-state for the edge detector, refresh counter, digit select and capture registers.
  always_comb begin
    w_loadEdge  = load & ~r_loadPrev;
    w_termCnt   = (r_cnt == CNT_LAST);
    w_cntNext   = w_termCnt ? '0 : r_cnt + 1'b1;
    w_selNext   = r_sel;
    if (w_termCnt) begin
      w_selNext = (r_sel == DIG_SUM) ? DIG_CARRY : DIG_SUM;
    end
    w_sumNext   = r_sum;
    w_carryNext = r_carry;
    w_validNext = r_valid;
    if (w_loadEdge) begin
      w_sumNext   = sum_in;
      w_carryNext = carry_in;
      w_validNext = 1'b1;
    end
    w_digit = (w_selNext == DIG_SUM) ? w_sumNext : {3'b000, w_carryNext};
  end

  hex_to_7seg u_decoder (
    .i_hex (w_digit),
    .o_seg (w_segDec)
  );

  // Choose digit enable and glyph for the cycle after this edge, blanking as needed.
  always_comb begin
    w_anNext  = AN_OFF;
    w_segNext = SEG_BLANK;
    if (w_validNext) begin
      if (w_selNext == DIG_SUM) begin
        w_anNext  = AN_SUM;
        w_segNext = w_segDec;
      end else begin
        w_anNext  = AN_CARRY;
        w_segNext = (BLANK_ZERO && !w_carryNext) ? SEG_BLANK : w_segDec;
      end
    end
  end

  // State and output registers; reset wins over any coincident load edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_loadPrev <= 1'b1;
      r_cnt      <= '0;
      r_sel      <= DIG_SUM;
      r_sum      <= 4'h0;
      r_carry    <= 1'b0;
      r_valid    <= 1'b0;
      r_loadAck  <= 1'b0;
      r_seg      <= SEG_BLANK;
      r_an       <= AN_OFF;
      r_ovf      <= 1'b0;
    end else begin
      r_loadPrev <= load;
      r_cnt      <= w_cntNext;
      r_sel      <= w_selNext;
      r_sum      <= w_sumNext;
      r_carry    <= w_carryNext;
      r_valid    <= w_validNext;
      r_loadAck  <= w_loadEdge;
      r_seg      <= w_segNext;
      r_an       <= w_anNext;
      r_ovf      <= w_carryNext;
    end
  end

  assign load_ack = r_loadAck;
  assign seg      = r_seg;
  assign an       = r_an;
  assign ovf_led  = r_ovf;

endmodule

// File: tb/tb_hex_sum_display.sv
// Scoreboard bench for hex_sum_display with a short refresh period.
module tb_hex_sum_display;

  localparam int RC = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       load;
  logic [3:0] sumIn;
  logic       carryIn;
  logic       loadAck;
  logic [6:0] seg;
  logic [1:0] an;
  logic       ovfLed;

  int compareCount  = 0;
  int mismatchCount = 0;

  logic [10:0] expQ[$];

  // Reference model state
  logic       mPrev  = 1'b1;
  int         mCnt   = 0;
  logic       mSel   = 1'b0;
  logic [3:0] mSum   = 4'h0;
  logic       mCarry = 1'b0;
  logic       mValid = 1'b0;

  int   ackCount;
  logic [6:0] segSeen;

  // Free-running clock, 10 time units per cycle.
  always #5 clk = ~clk;

  hex_sum_display #(
    .REFRESH_CNT (RC),
    .BLANK_ZERO  (1'b1)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .load     (load),
    .sum_in   (sumIn),
    .carry_in (carryIn),
    .load_ack (loadAck),
    .seg      (seg),
    .an       (an),
    .ovf_led  (ovfLed)
  );

  // Independent glyph table for the expected values.
  function automatic logic [6:0] glyph(input logic [3:0] v);
    case (v)
      4'h0: glyph = 7'h40;  4'h1: glyph = 7'h79;  4'h2: glyph = 7'h24;  4'h3: glyph = 7'h30;
      4'h4: glyph = 7'h19;  4'h5: glyph = 7'h12;  4'h6: glyph = 7'h02;  4'h7: glyph = 7'h78;
      4'h8: glyph = 7'h00;  4'h9: glyph = 7'h10;  4'hA: glyph = 7'h08;  4'hB: glyph = 7'h03;
      4'hC: glyph = 7'h46;  4'hD: glyph = 7'h21;  4'hE: glyph = 7'h06;  default: glyph = 7'h0E;
    endcase
  endfunction

  // Count one comparison and report it if the values differ.
  task automatic checkOutput(input string tag, input logic [10:0] obs, input logic [10:0] exp);
    compareCount++;
    if (obs !== exp) begin
      mismatchCount++;
      $display("[TB] FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  // Drive one cycle, advance the model, queue the expectation and compare after the edge.
  task automatic applyStimulus(input logic r, input logic l, input logic [3:0] s,
                               input logic c, input string tag);
    logic       edgeDet;
    logic       ack;
    logic [1:0] eAn;
    logic [6:0] eSeg;
    rst = r; load = l; sumIn = s; carryIn = c;
    if (r) begin
      mPrev = 1'b1; mCnt = 0; mSel = 1'b0; mSum = 4'h0; mCarry = 1'b0; mValid = 1'b0;
      ack = 1'b0;
    end else begin
      edgeDet = l && !mPrev;
      mPrev   = l;
      if (mCnt == RC - 1) begin
        mCnt = 0;
        mSel = !mSel;
      end else begin
        mCnt = mCnt + 1;
      end
      if (edgeDet) begin
        mSum = s; mCarry = c; mValid = 1'b1;
      end
      ack = edgeDet;
    end
    if (!mValid) begin
      eAn = 2'b11; eSeg = 7'h7F;
    end else if (!mSel) begin
      eAn = 2'b10; eSeg = glyph(mSum);
    end else begin
      eAn = 2'b01; eSeg = mCarry ? 7'h79 : 7'h7F;
    end
    expQ.push_back({ack, mCarry, eAn, eSeg});
    @(posedge clk);
    #1;
    checkOutput(tag, {loadAck, ovfLed, an, seg}, expQ.pop_front());
    if (loadAck === 1'b1) ackCount++;
  endtask

  // Idle with current inputs until the given digit is enabled, then return its glyph.
  task automatic waitDigit(input logic [1:0] target, input string tag, output logic [6:0] glyphOut);
    bit found = 0;
    for (int i = 0; i < 2 * RC + 2 && !found; i++) begin
      applyStimulus(1'b0, load, sumIn, carryIn, "idle");
      if (an === target) found = 1;
    end
    if (!found) checkOutput(tag, {9'b0, an}, {9'b0, target});
    glyphOut = seg;
  endtask

  initial begin
    rst = 1'b1; load = 1'b0; sumIn = 4'h0; carryIn = 1'b0;
    ackCount = 0;

    // Reset then idle: display stays dark, no acknowledges.
    repeat (2) applyStimulus(1'b1, 1'b0, 4'h0, 1'b0, "rst");
    repeat (20) applyStimulus(1'b0, 1'b0, 4'h0, 1'b0, "idleDark");
    checkOutput("idleAck", 11'(ackCount), 11'd0);
    checkOutput("idleDark", {4'b0, an, 5'b0}, {4'b0, 2'b11, 5'b0});

    // Sum A, carry 0, load held for ten cycles: one acknowledge only.
    ackCount = 0;
    repeat (10) applyStimulus(1'b0, 1'b1, 4'hA, 1'b0, "holdA");
    checkOutput("ackOnce", 11'(ackCount), 11'd1);
    waitDigit(2'b10, "waitSumA", segSeen);
    checkOutput("segA", {4'b0, segSeen}, {4'b0, 7'b0001000});
    waitDigit(2'b01, "waitCarry0", segSeen);
    checkOutput("blankCarry", {3'b0, ovfLed, segSeen}, {3'b0, 1'b0, 7'b1111111});

    // Sum F, carry 1, fresh edge; later sum change without edge is ignored.
    applyStimulus(1'b0, 1'b0, 4'hF, 1'b1, "dropLoad");
    applyStimulus(1'b0, 1'b1, 4'hF, 1'b1, "edgeF");
    checkOutput("ackF", {10'b0, loadAck}, 11'd1);
    waitDigit(2'b10, "waitSumF", segSeen);
    checkOutput("segF", {3'b0, ovfLed, segSeen}, {3'b0, 1'b1, 7'b0001110});
    waitDigit(2'b01, "waitCarry1", segSeen);
    checkOutput("segCarry1", {4'b0, segSeen}, {4'b0, 7'b1111001});
    repeat (3) applyStimulus(1'b0, 1'b1, 4'h3, 1'b1, "sum3NoEdge");
    waitDigit(2'b10, "waitSumStill", segSeen);
    checkOutput("segStillF", {4'b0, segSeen}, {4'b0, 7'b0001110});

    // Capture 8, then reset in the middle of the display.
    applyStimulus(1'b0, 1'b0, 4'h8, 1'b0, "drop8");
    applyStimulus(1'b0, 1'b1, 4'h8, 1'b0, "edge8");
    applyStimulus(1'b0, 1'b1, 4'h8, 1'b0, "hold8");
    applyStimulus(1'b1, 1'b1, 4'h8, 1'b0, "rstMid");
    checkOutput("rstMid", {loadAck, ovfLed, an, seg}, {1'b0, 1'b0, 2'b11, 7'b1111111});

    // Load held across reset: reset with a coincident edge, release, no capture until re-edge.
    applyStimulus(1'b0, 1'b0, 4'h7, 1'b0, "preLow");
    ackCount = 0;
    applyStimulus(1'b1, 1'b1, 4'h7, 1'b0, "rstEdge");
    applyStimulus(1'b1, 1'b1, 4'h7, 1'b0, "rstHold");
    repeat (6) applyStimulus(1'b0, 1'b1, 4'h7, 1'b0, "heldAfterRst");
    checkOutput("noCapture", {8'b0, ackCount[0], an}, {8'b0, 1'b0, 2'b11});
    applyStimulus(1'b0, 1'b0, 4'h7, 1'b0, "relLow");
    applyStimulus(1'b0, 1'b1, 4'h7, 1'b0, "reEdge");
    checkOutput("reCapture", {10'b0, loadAck}, 11'd1);

    // Load edge on the terminal-count cycle while the sum digit is selected.
    begin
      bit atTc = 0;
      int n = 0;
      do begin
        applyStimulus(1'b0, 1'b0, 4'h7, 1'b0, "seekTc");
        atTc = (mCnt == RC - 1) && !mSel;
        n++;
      end while (!atTc && n < 3 * RC);
      if (!atTc) checkOutput("seekTc", 11'd0, 11'd1);
      applyStimulus(1'b0, 1'b1, 4'h5, 1'b1, "edgeTc");
      checkOutput("tcCarry", {1'b0, loadAck, an, seg}, {1'b0, 1'b1, 2'b01, 7'b1111001});
      applyStimulus(1'b0, 1'b1, 4'h5, 1'b1, "afterTc");
      checkOutput("tcAckLow", {10'b0, loadAck}, 11'd0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
    $finish;
  end

endmodule

// File: doc/hex_sum_display.md
HEX_SUM_DISPLAY -- requirements
Module: hex_sum_display

Interface
REQ-001 SHALL have parameter REFRESH_CNT, default 50000, meaning clock cycles each digit stays active (legal range 2..2^20).
REQ-002 SHALL have parameter BLANK_ZERO, default 1, meaning blank digit 1 when the captured carry is 0.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 SHALL have port load, input, 1 bit: capture request, a level from a button or sequencer.
REQ-006 SHALL have port sum_in, input, 4 bits: hex sum from the adder stage.
REQ-007 SHALL have port carry_in, input, 1 bit: carry-out from the adder stage.
REQ-008 SHALL have port load_ack, output, 1 bit: one-cycle pulse confirming a capture.
REQ-009 SHALL have port seg, output, 7 bits: active-low segments, seg[0]=a through seg[6]=g.
REQ-010 SHALL have port an, output, 2 bits: active-low digit enables, an[0]=sum digit, an[1]=carry digit.
REQ-011 SHALL have port ovf_led, output, 1 bit: registered copy of the captured carry.

Function
REQ-012 SHALL detect a load rising edge as load=1 while the registered previous load is 0.
REQ-013 SHALL register sum_in and carry_in on the edge-detect cycle N, with new values driving the outputs from cycle N+1.
REQ-014 SHALL pulse load_ack high for exactly cycle N+1 and SHALL hold it low otherwise.
REQ-015 SHALL capture only once when load is held high for many cycles; a new capture requires load to return to 0 first.
REQ-016 SHALL set a valid flag on the first capture; the flag stays set until reset.
REQ-017 SHALL drive an=2'b11 and seg=7'b1111111 while valid=0.
REQ-018 SHALL run a refresh counter 0..REFRESH_CNT-1 that wraps to 0 and toggles digit select at terminal count, whether or not valid is set.
REQ-019 SHALL drive, when valid=1 and select=0, an=2'b10 and seg=hex decode of the captured sum.
REQ-020 SHALL drive, when valid=1 and select=1, an=2'b01 and seg=decode of the captured carry (0 or 1).
REQ-021 SHALL force seg=7'b1111111 during REQ-020 when BLANK_ZERO=1 and the captured carry is 0; an still follows REQ-020.
REQ-022 SHALL use hex decode 0=1000000, 1=1111001, 8=0000000, A=0001000, b=0000011, F=0001110 (seg[6:0]), with the standard glyphs for the remaining digits.
REQ-023 SHALL apply both events in the same cycle when a capture coincides with refresh terminal count: the newly selected digit shows the new data from N+1.
REQ-024 SHALL register seg, an and ovf_led, so there are no combinational paths from inputs to outputs.

Reset
REQ-025 SHALL, on rst=1 at a clock edge, reset: counter=0, select=0, captured sum=0, captured carry=0, valid=0, load_ack=0, ovf_led=0, an=2'b11, seg=7'b1111111.
REQ-026 SHALL reset the registered previous load to 1, so a load level held across reset release is not taken as an edge.
REQ-027 SHALL give rst priority over a simultaneous load edge; no capture and no load_ack occur in that cycle.
REQ-028 SHALL abandon any state mid-refresh or mid-capture on reset, with no residual load_ack.

Structure
REQ-029 SHALL place the 7-bit segment constants for 0..F and the blank value in shared package hex_disp_pkg.
REQ-030 SHALL implement the decoder as combinational sub-module hex_to_7seg (4-bit in, 7-bit seg out), instantiated once on the muxed digit value.
REQ-031 SHALL contain no other sub-modules; the edge detector, counter and mux are local.

Verification (REFRESH_CNT=4)
REQ-032 SHALL cover: rst for 2 cycles, then idle 20 cycles -> an=11, seg=1111111, load_ack never high.
REQ-033 SHALL cover: sum_in=A, carry_in=0, load high 10 cycles -> exactly one load_ack; digit0 seg=0001000; digit1 blank; ovf_led=0; select toggles every 4 cycles.
REQ-034 SHALL cover: sum_in=F, carry_in=1, load 0->1 -> ovf_led=1; digit0 seg=0001110; digit1 seg=1111001; sum_in changed to 3 afterwards without a load edge -> display unchanged.
REQ-035 SHALL cover: load edge on the refresh terminal-count cycle -> at N+1 an=01 with the new carry glyph, and load_ack=1.
REQ-036 SHALL cover: load held 1 across rst assertion and release -> no capture until load drops and rises again.
REQ-037 SHALL cover: rst mid-display after a capture of 8 -> next cycle all outputs at reset values and valid=0.
